variable_timer: RTL and testbench

VARIABLE_TIMER -- requirements
Module: variable_timer

---
 rtl/variable_timer_pkg.sv | 16 +
 rtl/variable_timer_mod_counter.sv | 25 ++
 rtl/variable_timer.sv | 71 +++++++
 tb/tb_variable_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/variable_timer_pkg.sv
// Shared constants and period arithmetic for the variable-period timer.
package variable_timer_pkg;

  localparam int BASE_PERIOD_MS   = 1000;
  localparam int PERIOD_STEP_MS   = 60;
  localparam int DEFAULT_TICK_DIV = 50000;
  localparam int SIM_TICK_DIV     = 5;

  typedef logic [3:0] speed_t;

  // 16-bit arithmetic keeps 1000 - 60*15 = 100 well clear of any wrap.
  function automatic logic [15:0] period_ms(input speed_t speed);
    return 16'(BASE_PERIOD_MS) - (16'(PERIOD_STEP_MS) * {12'd0, speed});
  endfunction

endpackage

// File: rtl/variable_timer_mod_counter.sv
// Modulo up-counter: counts 0..last while en is high, tc flags the wrap cycle.
module mod_counter
  import variable_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = en && (count == last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= (count == last) ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/variable_timer.sv
// Variable-period timer: 1 ms prescaler feeding a ms counter whose length follows Speed.
// Define VARIABLE_TIMER_SIM_FAST_EN to force a prescaler divide of 5 for simulation.
module variable_timer
  import variable_timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int MS_W     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] Speed,
  output logic       time_Out
);

`ifdef VARIABLE_TIMER_SIM_FAST_EN
  localparam int EFF_DIV = SIM_TICK_DIV;
`else
  localparam int EFF_DIV = TICK_DIV;
`endif

  localparam int PRE_W = ($clog2(EFF_DIV) > 16) ? $clog2(EFF_DIV) : 16;

  logic [PRE_W-1:0] pre_cnt;
  logic             pre_tc;
  logic [MS_W-1:0]  ms_cnt;
  logic [MS_W-1:0]  ms_last;
  logic             ms_tc;
  speed_t           speed_q;
  logic             period_start;

  // Period length comes from the latched code, so mid-period Speed changes are ignored.
  assign ms_last      = MS_W'(period_ms(speed_q) - 16'd1);
  assign period_start = enable && (pre_cnt == '0) && (ms_cnt == '0);

  mod_counter #(.WIDTH(PRE_W)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (enable),
    .last  (PRE_W'(EFF_DIV - 1)),
    .count (pre_cnt),
    .tc    (pre_tc)
  );

  mod_counter #(.WIDTH(MS_W)) u_ms_counter (
    .clock (clock),
    .reset (reset),
    .en    (pre_tc),
    .last  (ms_last),
    .count (ms_cnt),
    .tc    (ms_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      speed_q <= '0;
    end else if (period_start) begin
      speed_q <= Speed;
    end
  end

  // ms_tc already requires enable, so a paused timer can never pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_Out <= 1'b0;
    end else begin
      time_Out <= ms_tc;
    end
  end

endmodule

// File: tb/tb_variable_timer.sv
// Self-checking bench for variable_timer with a prescaler divide of 5.
module tb_variable_timer;

  localparam int DIV = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] Speed = 4'd0;
  logic       time_Out;

  always #5 clock = ~clock;

  variable_timer #(.TICK_DIV(DIV), .MS_W(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .Speed    (Speed),
    .time_Out (time_Out)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_q[$];
  logic prev_out = 1'b0;

  typedef struct {
    logic [3:0] speed;
    int         pulses;
    int         period;
  } vec_t;

  vec_t tbl[4];

  // Scoreboard: each pulse must land exactly on the cycle at the queue head.
  always @(negedge clock) begin
    int e;
    if (exp_q.size() > 0 && cyc > exp_q[0]) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse: no time_Out at cycle %0d, now cycle %0d", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (time_Out) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: time_Out=1 at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          miscompares++;
          $display("FAIL pulse_time: pulse at cycle %0d, required cycle %0d", cyc, e);
        end else begin
          $display("pulse at cycle %0d (expected %0d)", cyc, e);
        end
      end
      if (prev_out) begin
        miscompares++;
        $display("FAIL pulse_width: time_Out high two cycles running at cycle %0d", cyc);
      end
    end
    prev_out = time_Out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clock);
      check("reset_time_out", 32'(time_Out), 32'd0);
      check("reset_prescaler", 32'(dut.pre_cnt), 32'd0);
      check("reset_ms_count", 32'(dut.ms_cnt), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic start(input logic [3:0] s, output int t0);
    Speed  = s;
    enable = 1'b1;
    t0     = cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic drain(input int limit);
    int g = 0;
    while (exp_q.size() > 0 && g < limit) begin
      @(negedge clock);
      g++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d pulses outstanding after %0d cycles", exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  initial begin
    int t0;
    int t1;
    tbl[0] = '{speed: 4'd2,  pulses: 2, period: 4400};
    tbl[1] = '{speed: 4'd0,  pulses: 2, period: 5000};
    tbl[2] = '{speed: 4'd15, pulses: 4, period: 500};
    tbl[3] = '{speed: 4'd7,  pulses: 2, period: 2900};

    for (int i = 0; i < 4; i++) begin
      do_reset();
      start(tbl[i].speed, t0);
      for (int k = 1; k <= tbl[i].pulses; k++) exp_q.push_back(t0 + k * tbl[i].period);
      drain(tbl[i].period * tbl[i].pulses + 50);
      $display("case speed=%0d period=%0d pulses=%0d done", tbl[i].speed, tbl[i].period, tbl[i].pulses);
    end

    // Speed change mid-period only affects the following period.
    do_reset();
    start(4'd2, t0);
    exp_q.push_back(t0 + 4400);
    exp_q.push_back(t0 + 4900);
    exp_q.push_back(t0 + 5400);
    wait_until(t0 + 1000);
    Speed = 4'd15;
    drain(6000);
    $display("speed change sequence done");

    // Pause for 300 cycles delays the pulse by exactly 300.
    do_reset();
    start(4'd2, t0);
    exp_q.push_back(t0 + 4700);
    exp_q.push_back(t0 + 9100);
    wait_until(t0 + 1000);
    enable = 1'b0;
    repeat (300) begin
      @(negedge clock);
      check("paused_time_out", 32'(time_Out), 32'd0);
    end
    enable = 1'b1;
    drain(9000);
    $display("pause sequence done");

    // Reset mid-period aborts it; restart samples the Speed present at release.
    do_reset();
    start(4'd2, t0);
    exp_q.push_back(t0 + 4400);
    wait_until(t0 + 2000);
    reset = 1'b0;
    exp_q.delete();
    Speed = 4'd15;
    #1;
    check("async_reset_time_out", 32'(time_Out), 32'd0);
    check("async_reset_prescaler", 32'(dut.pre_cnt), 32'd0);
    check("async_reset_ms_count", 32'(dut.ms_cnt), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    t1 = cyc;
    exp_q.push_back(t1 + 500);
    exp_q.push_back(t1 + 1000);
    drain(1100);
    $display("mid-period reset sequence done");

    // Enable dropped on the terminal-count cycle suppresses the wrap.
    do_reset();
    start(4'd15, t0);
    exp_q.push_back(t0 + 510);
    wait_until(t0 + 499);
    enable = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("terminal_pause_time_out", 32'(time_Out), 32'd0);
    end
    enable = 1'b1;
    drain(100);
    $display("terminal-count pause sequence done");

    enable = 1'b0;
    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
